// File: rtl/pc_jump_ctrl.sv
// Branch/jump redirect controller feeding the fetch PC jump mux.
// Optional redirect/stall counters are enabled with `define PC_JUMP_STAT_EN.
module pc_jump_ctrl #(
  parameter int unsigned PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic                ex_branch,
  input  logic                ex_jump,
  input  logic                ex_cond,
  input  logic [PC_WIDTH-1:0] ex_target,
  input  logic                if_stall,
`ifdef PC_JUMP_STAT_EN
  input  logic                stat_clr,
  output logic [31:0]         jump_cnt,
  output logic [31:0]         stall_cnt,
`endif
  output logic                PC_jump_op,
  output logic [PC_WIDTH-1:0] PC_jump,
  output logic                flush_if,
  output logic                flush_id,
  output logic                jump_pending
);

  localparam logic PC_JUMP_ENABLE  = 1'b1;
  localparam logic PC_JUMP_DISABLE = 1'b0;

  typedef enum logic [0:0] {StIdle, StRedirect} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic [PC_WIDTH-1:0] r_pc_jump;
  logic                w_take;
  logic                w_capture;
  logic                w_stall_hit;

  assign w_take      = ex_valid & (ex_jump | (ex_branch & ex_cond));
  // EX inputs only matter in IDLE; in REDIRECT they are wrong-path.
  assign w_capture   = (r_state == StIdle) & w_take;
  assign w_stall_hit = (r_state == StRedirect) & if_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:     if (w_take) w_state_d = StRedirect;
      StRedirect: if (!if_stall) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  // Outputs decode the state register only, so they never glitch from inputs.
  always_comb begin
    PC_jump_op   = PC_JUMP_DISABLE;
    flush_if     = 1'b0;
    flush_id     = 1'b0;
    jump_pending = 1'b0;
    if (r_state == StRedirect) begin
      PC_jump_op   = PC_JUMP_ENABLE;
      flush_if     = 1'b1;
      flush_id     = 1'b1;
      jump_pending = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_jump <= '0;
    end else if (w_capture) begin
      r_pc_jump <= ex_target;
    end
  end

  assign PC_jump = r_pc_jump;

`ifdef PC_JUMP_STAT_EN
  logic [31:0] r_jump_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jump_cnt  <= '0;
      r_stall_cnt <= '0;
    end else if (stat_clr) begin
      r_jump_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_capture)   r_jump_cnt  <= r_jump_cnt + 32'd1;
      if (w_stall_hit) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign jump_cnt  = r_jump_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  logic w_unused;
  assign w_unused = w_stall_hit;
`endif

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Directed self-checking bench for pc_jump_ctrl; inputs change 1ns after a rising edge
// and outputs are checked there too, so each tick() covers exactly one clock edge.
module tb_pc_jump_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_jump;
  logic        ex_cond;
  logic [15:0] ex_target;
  logic        if_stall;
  logic        stat_clr;
  logic        PC_jump_op;
  logic [15:0] PC_jump;
  logic        flush_if;
  logic        flush_id;
  logic        jump_pending;
`ifdef PC_JUMP_STAT_EN
  logic [31:0] jump_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pc_jump_ctrl #(.PC_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_branch    (ex_branch),
    .ex_jump      (ex_jump),
    .ex_cond      (ex_cond),
    .ex_target    (ex_target),
    .if_stall     (if_stall),
`ifdef PC_JUMP_STAT_EN
    .stat_clr     (stat_clr),
    .jump_cnt     (jump_cnt),
    .stall_cnt    (stall_cnt),
`endif
    .PC_jump_op   (PC_jump_op),
    .PC_jump      (PC_jump),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .jump_pending (jump_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic b, input logic j, input logic c,
                       input logic [15:0] t, input logic s);
    ex_valid  = v;
    ex_branch = b;
    ex_jump   = j;
    ex_cond   = c;
    ex_target = t;
    if_stall  = s;
  endtask

  task automatic chk_redirect(input string tag, input logic on, input logic [15:0] pc);
    chk({tag, ".op"}, {31'd0, PC_jump_op}, {31'd0, on});
    chk({tag, ".pc"}, {16'd0, PC_jump}, {16'd0, pc});
    chk({tag, ".fif"}, {31'd0, flush_if}, {31'd0, on});
    chk({tag, ".fid"}, {31'd0, flush_id}, {31'd0, on});
    chk({tag, ".pend"}, {31'd0, jump_pending}, {31'd0, on});
  endtask

  initial begin
    rst_n    = 1'b0;
    stat_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

    // Reset held while a taken jump is presented
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF, 1'b0);
    tick();
    tick();
    chk_redirect("rst_hold", 1'b0, 16'h0000);
`ifdef PC_JUMP_STAT_EN
    chk("rst_jcnt", jump_cnt, 32'd0);
    chk("rst_scnt", stall_cnt, 32'd0);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_redirect("post_rst", 1'b0, 16'h0000);

    // Taken branch, no stall: one REDIRECT cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b0);
    tick();
    chk_redirect("br_taken", 1'b1, 16'h0040);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    chk_redirect("br_done", 1'b0, 16'h0040);

    // Not-taken branch, then invalid jump
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b0);
    tick();
    chk_redirect("br_nt", 1'b0, 16'h0040);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h00C0, 1'b0);
    tick();
    chk_redirect("jmp_inv", 1'b0, 16'h0040);

    // Stall hold with a wrong-path take during REDIRECT
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0);
    tick();
    chk_redirect("stall_c1", 1'b1, 16'h1234);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h5678, 1'b1);
    tick();
    chk_redirect("stall_c2", 1'b1, 16'h1234);
    tick();
    chk_redirect("stall_c3", 1'b1, 16'h1234);
    tick();
    chk_redirect("stall_c4", 1'b1, 16'h1234);
`ifdef PC_JUMP_STAT_EN
    chk("stall_scnt", stall_cnt, 32'd3);
`endif
    // Take coincident with REDIRECT->IDLE must be ignored
    if_stall = 1'b0;
    tick();
    chk_redirect("b2b_ign", 1'b0, 16'h1234);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    chk_redirect("b2b_idle", 1'b0, 16'h1234);
`ifdef PC_JUMP_STAT_EN
    chk("two_jcnt", jump_cnt, 32'd2);
    chk("two_scnt", stall_cnt, 32'd3);
`endif

    // Jump and branch together with cond=0 is still taken
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 1'b0);
    tick();
    chk_redirect("jb_both", 1'b1, 16'h0100);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    chk_redirect("jb_done", 1'b0, 16'h0100);

    // Asynchronous reset mid-REDIRECT
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0ABC, 1'b1);
    tick();
    chk_redirect("mid_pre", 1'b1, 16'h0ABC);
    #2;
    rst_n = 1'b0;
    #1;
    chk_redirect("mid_rst", 1'b0, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_redirect("mid_rel", 1'b0, 16'h0000);

    // Misaligned target passes through unmodified
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0);
    tick();
    chk_redirect("misalign", 1'b1, 16'h0003);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();

`ifdef PC_JUMP_STAT_EN
    chk("cnt_after_rst", jump_cnt, 32'd1);
    // stat_clr beats a same-cycle redirect
    stat_clr = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0200, 1'b0);
    tick();
    chk("clr_jcnt", jump_cnt, 32'd0);
    chk_redirect("clr_redir", 1'b1, 16'h0200);
    stat_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
    // Wrap from all-ones
    force dut.r_jump_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_jump_cnt;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0300, 1'b0);
    tick();
    chk("wrap_jcnt", jump_cnt, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_jump_ctrl.md
# pc_jump_ctrl

Branch/jump redirect controller for the fetch stage; it produces the select and target that the PC jump mux consumes. It takes branch and jump resolution results from EX and drives `PC_jump_op`/`PC_jump` toward fetch. It holds a redirect request across fetch stalls until fetch accepts it, and squashes the wrong-path IF/ID contents.

## Interface
- `PC_WIDTH`, default 16: width of every PC/target bus; matches `PC_BUS`.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `ex_valid  in  1`: EX holds a valid instruction this cycle.
- `ex_branch  in  1`: the EX instruction is a conditional branch.
- `ex_jump  in  1`: the EX instruction is an unconditional jump.
- `ex_cond  in  1`: branch condition result; meaningful only with `ex_branch`.
- `ex_target  in  PC_WIDTH`: resolved target address.
- `if_stall  in  1`: the fetch PC register holds this cycle and ignores its input.
- `PC_jump_op  out  1`: mux select; `PC_JUMP_ENABLE` selects the target, `PC_JUMP_DISABLE` selects the sequential PC.
- `PC_jump  out  PC_WIDTH`: redirect target.
- `flush_if  out  1`: squash the IF/ID register.
- `flush_id  out  1`: squash the ID/EX register.
- `jump_pending  out  1`: a redirect is outstanding.
- With `PC_JUMP_STAT_EN` only:
  - `stat_clr  in  1`: synchronous clear of both counters.
  - `jump_cnt  out  32`: number of accepted redirects.
  - `stall_cnt  out  32`: number of REDIRECT cycles that saw `if_stall`.

## Operation
- Take condition: `take = ex_valid & (ex_jump | (ex_branch & ex_cond))`. If `ex_jump` and `ex_branch` are both high, the instruction is treated as a jump and is taken regardless of `ex_cond`.
- FSM has two states, IDLE and REDIRECT. All outputs are registered.
- **IDLE:**
  - `take` → capture `ex_target` into `PC_jump` and go to REDIRECT.
  - No `take` → stay in IDLE; `PC_jump` keeps its last value.
- **REDIRECT:**
  - `PC_jump_op = PC_JUMP_ENABLE`, `flush_if = flush_id = jump_pending = 1`.
  - `PC_jump` is frozen for the whole state.
  - `if_stall = 0` → fetch loads `PC_jump` on this edge; go to IDLE.
  - `if_stall = 1` → stay in REDIRECT.
  - EX inputs are ignored: they belong to the wrong path, which is being flushed.
- **IDLE outputs:** `PC_jump_op = PC_JUMP_DISABLE`; `flush_if`, `flush_id` and `jump_pending` are 0.
- **Reset values:** state IDLE, `PC_jump = 0`, `PC_jump_op = PC_JUMP_DISABLE`, all flags 0, counters 0. Reset asserted mid-REDIRECT drops the request immediately; no redirect is issued after release.
- **Back-to-back:** a `take` in the cycle of the REDIRECT→IDLE transition is ignored, because that instruction is itself being flushed. The next `take` is accepted only in IDLE.
- **Misaligned target:** `ex_target` is passed through unmodified; alignment checks belong to fetch.

## Timing
- Latency: `take` sampled at edge N → `PC_jump_op`/`PC_jump`/flushes valid throughout cycle N+1.
- With no stall, fetch loads the target at edge N+1, and REDIRECT lasts exactly 1 cycle.
- With stall: REDIRECT lasts 1 + k cycles for k consecutive stalled cycles starting at N+1. `PC_jump` is stable for that entire span.
- `PC_jump_op` and the flush signals are high in exactly the same cycles and are never glitched combinationally from inputs.

## Configuration
- `PC_JUMP_STAT_EN` defined:
  - Adds `stat_clr`, `jump_cnt` and `stall_cnt`.
  - `jump_cnt` increments on each IDLE→REDIRECT transition.
  - `stall_cnt` increments on each REDIRECT cycle with `if_stall = 1`.
  - Both counters are 32 bits and wrap from 0xFFFFFFFF to 0.
  - `stat_clr` has priority over a same-cycle increment; the counter becomes 0.
- `PC_JUMP_STAT_EN` undefined: none of these ports or counters exist, and redirect behaviour is identical.

## Test plan
- **Reset:** hold `rst_n = 0`, toggle inputs → `PC_jump_op = PC_JUMP_DISABLE`, `PC_jump = 0x0000`, flushes 0. Assert `rst_n` low mid-REDIRECT → outputs clear without waiting for a clock edge.
- **Taken branch, no stall:** `ex_valid = 1`, `ex_branch = 1`, `ex_cond = 1`, `ex_target = 0x0040` at edge N → during cycle N+1 `PC_jump_op = ENABLE`, `PC_jump = 0x0040`, `flush_if = flush_id = 1`; at N+2 back to DISABLE.
- **Not-taken branch:** `ex_branch = 1`, `ex_cond = 0` → no state change and `PC_jump_op` stays DISABLE. Same result with `ex_valid = 0` and `ex_jump = 1`.
- **Stall hold:** jump to 0x1234 with `if_stall = 1` for 3 cycles → REDIRECT lasts 4 cycles and `PC_jump` stays 0x1234. A second `take` to 0x5678 during REDIRECT does not change `PC_jump`.
- **Jump and branch together:** `ex_jump = 1`, `ex_branch = 1`, `ex_cond = 0`, target 0x0100 → redirect to 0x0100.
- **Stats (`PC_JUMP_STAT_EN`):** 2 redirects, one with 3 stall cycles → `jump_cnt = 2`, `stall_cnt = 3`. Assert `stat_clr` coincident with a new redirect → `jump_cnt = 0`. Preload `0xFFFFFFFF` via force → wraps to 0 on the next redirect.
